// File: rtl/ula.sv
// 32-bit MIPS-style ALU: eight ops selected by ULA_cpntrol, registered result and Zero flag.
// One-cycle latency, a new operation every cycle, no handshake.
module ula #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada_01,
  input  logic [WIDTH-1:0] entrada_02,
  input  logic [2:0]       ULA_cpntrol,
  output logic [WIDTH-1:0] ULA_result,
  output logic             Zero
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic [WIDTH-1:0] diff;
  logic             slt;

  always_comb begin
    diff = entrada_01 - entrada_02;
    // Differing signs decide SLT directly; the difference's sign bit is only trusted when it cannot overflow.
    if (entrada_01[WIDTH-1] != entrada_02[WIDTH-1]) begin
      slt = entrada_01[WIDTH-1];
    end else begin
      slt = diff[WIDTH-1];
    end

    result_d = '0;
    case (ULA_cpntrol)
      3'b000:  result_d = entrada_01 & entrada_02;
      3'b001:  result_d = entrada_01 | entrada_02;
      3'b010:  result_d = entrada_01 + entrada_02;
      3'b011:  result_d = '0;
      3'b100:  result_d = entrada_01 & ~entrada_02;
      3'b101:  result_d = entrada_01 | ~entrada_02;
      3'b110:  result_d = diff;
      3'b111:  result_d = {{(WIDTH-1){1'b0}}, slt};
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ULA_result = result_q;
  assign Zero       = zero_q;

endmodule

// File: tb/tb_ula.sv
// Directed-vector bench for ula: table of hand-computed results plus reset and hold sequences.
module tb_ula;

  logic        clk;
  logic        rst;
  logic [31:0] entrada_01;
  logic [31:0] entrada_02;
  logic [2:0]  ULA_cpntrol;
  logic [31:0] ULA_result;
  logic        Zero;

  int total;
  int bad;

  ula #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .entrada_01  (entrada_01),
    .entrada_02  (entrada_02),
    .ULA_cpntrol (ULA_cpntrol),
    .ULA_result  (ULA_result),
    .Zero        (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [0:19];

  task automatic check(input string name, input logic [31:0] exp_res, input logic exp_zero);
    total++;
    if (ULA_result !== exp_res || Zero !== exp_zero) begin
      bad++;
      $display("FAIL %s: got result=%08h zero=%b, want result=%08h zero=%b",
               name, ULA_result, Zero, exp_res, exp_zero);
    end
  endtask

  // Drive on the falling edge, check on the next falling edge, so each result is seen one edge later.
  task automatic step(input string name, input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic [31:0] exp_res, input logic exp_zero);
    rst         = r;
    entrada_01  = a;
    entrada_02  = b;
    ULA_cpntrol = c;
    @(negedge clk);
    check(name, exp_res, exp_zero);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; entrada_01 = '0; entrada_02 = '0; ULA_cpntrol = 3'b000;

    vecs[0]  = '{1'b1, 32'hDEADBEEF, 32'h12345678, 3'b010, 32'h00000000, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000000F, 32'h00000001, 3'b010, 32'h00000010, 1'b0};
    vecs[2]  = '{1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b000, 32'h00000000, 1'b1};
    vecs[3]  = '{1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b100, 32'hA5A5A5A5, 1'b0};
    vecs[5]  = '{1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b101, 32'hA5A5A5A5, 1'b0};
    vecs[6]  = '{1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b011, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000000F, 32'h0000000F, 3'b110, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, 32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000000A, 32'h0000000F, 3'b111, 32'h00000001, 1'b0};
    vecs[10] = '{1'b0, 32'h0000000F, 32'h0000000A, 3'b111, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 32'h80000000, 32'h00000001, 3'b111, 32'h00000001, 1'b0};
    vecs[12] = '{1'b0, 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 32'h80000000, 32'h00000000, 3'b111, 32'h00000001, 1'b0};
    vecs[14] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1};
    vecs[15] = '{1'b0, 32'h12345678, 32'h12345678, 3'b111, 32'h00000000, 1'b1};
    vecs[16] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0};
    vecs[17] = '{1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1};
    vecs[18] = '{1'b0, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0};
    vecs[19] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0};

    @(negedge clk);
    // Consecutive vectors change every cycle, so this loop also exercises back-to-back issue.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].ctrl,
           vecs[i].exp_res, vecs[i].exp_zero);
    end

    // Mid-stream reset: the operation sampled with rst=1 is discarded.
    step("stream_add0", 1'b0, 32'h00000001, 32'h00000002, 3'b010, 32'h00000003, 1'b0);
    step("stream_rst",  1'b1, 32'h00000005, 32'h00000006, 3'b010, 32'h00000000, 1'b1);
    step("stream_add1", 1'b0, 32'h00000007, 32'h00000008, 3'b010, 32'h0000000F, 1'b0);
    step("stream_add2", 1'b0, 32'h00000010, 32'h00000020, 3'b010, 32'h00000030, 1'b0);

    // Output must be valid just after the edge and stay put until the next one.
    rst = 1'b0; entrada_01 = 32'hF0F0F0F0; entrada_02 = 32'h0F0F0F0F; ULA_cpntrol = 3'b001;
    @(posedge clk);
    #1;
    check("hold_early", 32'hFFFFFFFF, 1'b0);
    entrada_01 = 32'h00000000; entrada_02 = 32'h00000000; ULA_cpntrol = 3'b000;
    #3;
    check("hold_late", 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("hold_next", 32'h00000000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula.md
Name: ula

Overview:
- 32-bit arithmetic/logic unit for the single-cycle/multicycle MIPS-style datapath.
- Selects one of eight operations via a 3-bit control code and produces a result and a Zero flag for branch decisions.
- Inputs are sampled on the rising clock edge and outputs are registered, giving 1-cycle latency.

Parameters:
- WIDTH, 32, data width of both operands and the result.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- entrada_01  input  WIDTH  operand A.
- entrada_02  input  WIDTH  operand B.
- ULA_cpntrol  input  3  operation select; the port name is spelled exactly so.
- ULA_result  output  WIDTH  registered operation result.
- Zero  output  1  registered flag; 1 when ULA_result is all zeros.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high: on a rising clk edge with rst=1, ULA_result <= 0 and Zero <= 1.
  - rst takes priority over all other inputs in that cycle.
- Latency:
  - Operands and control sampled at rising edge N appear on ULA_result and Zero after edge N.
  - Outputs hold steady until the next edge.
  - A new operation may be issued every cycle, i.e. full throughput with no handshake.
- Operation decode (A = entrada_01, B = entrada_02):
  - 000: A AND B (bitwise).
  - 001: A OR B (bitwise).
  - 010: A + B, modulo 2^WIDTH; carry-out discarded, no overflow flag.
  - 011: reserved; result = 0.
  - 100: A AND (NOT B).
  - 101: A OR (NOT B).
  - 110: A - B, modulo 2^WIDTH (two's complement; borrow discarded).
  - 111: set-less-than, signed. Result = 1 (zero-extended to WIDTH) when A < B as two's-complement numbers, else 0.
- SLT sign handling:
  - Compute from A - B and the operand signs.
  - When signs differ, result = sign bit of A.
  - This avoids the overflow error of using the subtraction sign bit alone.
- Zero: computed from the same-cycle combinational result and registered together with ULA_result, so Zero always equals (ULA_result == 0).
- Unknown/X on ULA_cpntrol is not supported; all 8 codes are defined, so no latch or undefined output.
- Boundary conditions:
  - ADD 0xFFFFFFFF + 1 wraps to 0 with Zero=1.
  - SUB 0 - 1 gives 0xFFFFFFFF.
  - SLT 0x80000000 vs 0x00000000 gives 1; 0x7FFFFFFF vs 0x80000000 gives 0.
  - SLT with A == B gives 0 and Zero=1.
  - Reset asserted mid-stream discards the operation sampled in that cycle; the next cycle after rst deasserts computes normally.

Test Plan:
- Reset: rst=1 for one edge with arbitrary operands -> ULA_result=0x00000000, Zero=1. Deassert rst with A=0x0000000F, B=0x00000001, ctrl=010 -> next edge ULA_result=0x00000010, Zero=0.
- Logic ops: A=0xA5A5A5A5, B=0x5A5A5A5A:
  - ctrl=000 -> 0x00000000, Zero=1.
  - ctrl=001 -> 0xFFFFFFFF, Zero=0.
  - ctrl=100 -> 0xA5A5A5A5.
  - ctrl=101 -> 0xA5A5A5A5.
  - ctrl=011 -> 0x00000000, Zero=1.
- Subtract and Zero flag:
  - A=0x0000000F, B=0x0000000F, ctrl=110 -> 0x00000000, Zero=1.
  - A=0, B=1, ctrl=110 -> 0xFFFFFFFF, Zero=0.
- SLT signed:
  - A=0x0000000A, B=0x0000000F, ctrl=111 -> 0x00000001.
  - Swap operands -> 0x00000000, Zero=1.
  - A=0x80000000, B=0x00000001 -> 0x00000001.
  - A=0x7FFFFFFF, B=0x80000000 -> 0x00000000.
- Wrap and throughput:
  - A=0xFFFFFFFF, B=1, ctrl=010 -> 0x00000000, Zero=1.
  - Back-to-back different ops on consecutive edges -> each result appears exactly one cycle after its inputs, with no bubbles.
- Mid-stream reset: stream ADD ops, assert rst for one cycle -> that cycle's output is 0 with Zero=1, and the following op's result is correct.
